// File: rtl/pixel_imex_stream.sv
// pixel_imex_stream
// Pixel import/export stage: accepts packed multi-channel pixels on a
// valid/ready stream, applies a per-pixel channel transform when the pixel is
// accepted, buffers pixels in a DEPTH-entry FIFO and presents them downstream
// through registered o_valid/o_data. It also keeps a sticky error flag and a
// count of delivered pixels.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-low
//   i_valid    upstream pixel valid
//   i_data     packed pixel, channel k at [k*CW +: CW]
//   i_ready    registered: block can accept a pixel this cycle
//   i_mode     transform for the pixel accepted this cycle
//              (00 pass, 01 channel reverse, 10 invert, 11 reserved)
//   i_err_clr  clears o_error (a simultaneous set condition wins)
//   o_valid    o_data holds a valid pixel
//   o_data     packed output pixel (registered copy of the FIFO head)
//   o_ready    downstream accepts the pixel this cycle
//   o_error    sticky error: reserved mode pushed, or upstream dropped/changed
//              a stalled pixel
//   o_count    pixels delivered downstream, modulo 2^CNTW
module pixel_imex_stream #(
   parameter int CH    = 3,
   parameter int CW    = 8,
   parameter int DEPTH = 4,
   parameter int CNTW  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic [CH*CW-1:0]    i_data,
   output logic                i_ready,
   input  logic [1:0]          i_mode,
   input  logic                i_err_clr,
   output logic                o_valid,
   output logic [CH*CW-1:0]    o_data,
   input  logic                o_ready,
   output logic                o_error,
   output logic [CNTW-1:0]     o_count
);

   localparam int DW = CH * CW;
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_REV  = 2'b01,
      MODE_INV  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          stall_q;
   logic [DW-1:0] stall_data;

   logic          push;
   logic          pop;
   logic [DW-1:0] px_in;
   logic [AW-1:0] next_rd;
   logic [AW:0]   remaining;
   logic [AW:0]   next_count;
   logic [DW-1:0] head;
   logic          err_set;

   // Channel transform; inverting every channel to (2^CW-1)-v is a plain
   // bitwise complement of the whole packed word.
   function automatic logic [DW-1:0] transform(input logic [DW-1:0] px,
                                               input logic [1:0] mode);
      logic [DW-1:0] r;
      r = px;
      case (mode)
         MODE_REV: begin
            for (int k = 0; k < CH; k++) begin
               r[k*CW +: CW] = px[(CH-1-k)*CW +: CW];
            end
         end
         MODE_INV: r = ~px;
         default:  r = px;
      endcase
      return r;
   endfunction

   // Handshakes, next occupancy and the pixel that will sit at the FIFO head
   // after this edge. When the FIFO drains to nothing before the push, the
   // pixel being pushed becomes the head directly, which gives single-cycle
   // latency and no bubble on simultaneous push/pop with one entry.
   always_comb begin
      push       = i_valid && i_ready;
      pop        = o_valid && o_ready;
      px_in      = transform(i_data, i_mode);
      next_rd    = pop ? rd_ptr + AW'(1) : rd_ptr;
      remaining  = count - {{AW{1'b0}}, pop};
      next_count = remaining + {{AW{1'b0}}, push};
      head       = (remaining == '0) ? px_in : mem[next_rd];
      err_set    = (push && (i_mode == MODE_RSVD)) ||
                   (stall_q && (!i_valid || (i_data != stall_data)));
   end

   // Pixel storage; the pointers are cleared by reset, so stale entries are
   // simply unreachable and the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem[wr_ptr] <= px_in;
      end
   end

   // Pointers, occupancy, registered handshake outputs, counter and error.
   // i_ready depends only on the next occupancy, so there is no
   // combinational path from o_ready to i_ready. o_data only changes when a
   // pixel will be valid, which keeps it stable while downstream stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         i_ready    <= 1'b1;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_error    <= 1'b0;
         o_count    <= '0;
         stall_q    <= 1'b0;
         stall_data <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr  <= next_rd;
         count   <= next_count;
         i_ready <= (next_count < FULL_CNT);
         o_valid <= (next_count != '0);
         if (next_count != '0) begin
            o_data <= head;
         end
         if (pop) begin
            o_count <= o_count + CNTW'(1);
         end
         if (err_set) begin
            o_error <= 1'b1;
         end else if (i_err_clr) begin
            o_error <= 1'b0;
         end
         stall_q    <= i_valid && !i_ready;
         stall_data <= i_data;
      end
   end

endmodule

// File: tb/tb_pixel_imex_stream.sv
// tb_pixel_imex_stream
// Self-checking bench for pixel_imex_stream (CH=3, CW=8, DEPTH=4, CNTW=4).
// A queue-based reference model tracks the pixels held by the block, the
// registered ready, the sticky error and the delivered count; every cycle the
// DUT outputs are compared against it, plus fixed expected values for the
// directed scenarios, followed by a randomized run.
module tb_pixel_imex_stream;

   localparam int CH    = 3;
   localparam int CW    = 8;
   localparam int DEPTH = 4;
   localparam int CNTW  = 4;
   localparam int DW    = CH * CW;

   logic            clk;
   logic            rst;
   logic            i_valid;
   logic [DW-1:0]   i_data;
   logic            i_ready;
   logic [1:0]      i_mode;
   logic            i_err_clr;
   logic            o_valid;
   logic [DW-1:0]   o_data;
   logic            o_ready;
   logic            o_error;
   logic [CNTW-1:0] o_count;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] m_q [$];
   logic          m_ready;
   logic          m_err;
   int            m_cnt;
   logic          m_prev_stall;
   logic [DW-1:0] m_prev_data;
   logic          m_fresh;

   pixel_imex_stream #(
      .CH(CH), .CW(CW), .DEPTH(DEPTH), .CNTW(CNTW)
   ) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
      .i_mode(i_mode), .i_err_clr(i_err_clr),
      .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
      .o_error(o_error), .o_count(o_count)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case anything stalls the main sequence.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference transform: split into channel values and apply the rule with
   // plain integer arithmetic.
   function automatic logic [DW-1:0] refXform(input logic [DW-1:0] px,
                                              input logic [1:0] mode);
      int ch [CH];
      int outc [CH];
      logic [DW-1:0] r;
      for (int k = 0; k < CH; k++) ch[k] = int'((px >> (k*CW)) & ((1 << CW) - 1));
      for (int k = 0; k < CH; k++) begin
         case (mode)
            2'b01:   outc[k] = ch[CH-1-k];
            2'b10:   outc[k] = ((1 << CW) - 1) - ch[k];
            default: outc[k] = ch[k];
         endcase
      end
      r = '0;
      for (int k = 0; k < CH; k++) r = r | (DW'(outc[k]) << (k*CW));
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelEdge();
      logic push;
      logic pop;
      logic viol;
      if (!rst) begin
         m_q.delete();
         m_ready      = 1'b1;
         m_err        = 1'b0;
         m_cnt        = 0;
         m_prev_stall = 1'b0;
         m_prev_data  = '0;
         m_fresh      = 1'b1;
         return;
      end
      push = i_valid && m_ready;
      pop  = (m_q.size() > 0) && o_ready;
      viol = m_prev_stall && (!i_valid || (i_data != m_prev_data));
      if (pop) begin
         void'(m_q.pop_front());
         m_cnt++;
      end
      if (push) begin
         m_q.push_back(refXform(i_data, i_mode));
         m_fresh = 1'b0;
      end
      if ((push && i_mode == 2'b11) || viol) m_err = 1'b1;
      else if (i_err_clr)                    m_err = 1'b0;
      m_prev_stall = i_valid && !m_ready;
      m_prev_data  = i_data;
      m_ready      = (m_q.size() < DEPTH);
   endtask

   task automatic compareAll();
      checkOutput("i_ready", 32'(i_ready), 32'(m_ready));
      checkOutput("o_valid", 32'(o_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0)  checkOutput("o_data", 32'(o_data), 32'(m_q[0]));
      else if (m_fresh)    checkOutput("o_data_rst", 32'(o_data), 32'h0);
      checkOutput("o_error", 32'(o_error), 32'(m_err));
      checkOutput("o_count", 32'(o_count), 32'(m_cnt & ((1 << CNTW) - 1)));
   endtask

   // Drive one cycle of inputs just after a falling edge, let the rising edge
   // happen, update the model, then compare at the next falling edge.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                input logic [1:0] m, input logic ordy,
                                input logic clr, input logic r);
      i_valid   = v;
      i_data    = d;
      i_mode    = m;
      o_ready   = ordy;
      i_err_clr = clr;
      rst       = r;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      compareAll();
   endtask

   initial begin
      int pushed;
      logic acc;
      logic pend;
      logic [DW-1:0] pend_d;
      logic rv;
      logic [DW-1:0] rd;
      logic rr;

      rst = 1'b0; i_valid = 1'b0; i_data = '0; i_mode = 2'b00;
      o_ready = 1'b0; i_err_clr = 1'b0;
      m_q.delete(); m_ready = 1'b1; m_err = 1'b0; m_cnt = 0;
      m_prev_stall = 1'b0; m_prev_data = '0; m_fresh = 1'b1;

      // Reset held for three cycles while upstream offers a pixel.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 24'h5A5A5A, 2'b00, 1'b1, 1'b0, 1'b0);
         checkOutput("rst_ready", 32'(i_ready), 32'h1);
         checkOutput("rst_valid", 32'(o_valid), 32'h0);
         checkOutput("rst_data", 32'(o_data), 32'h0);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);
         checkOutput("idle_valid", 32'(o_valid), 32'h0);
      end

      // Latency and transform modes with downstream always ready.
      applyStimulus(1'b1, 24'h112233, 2'b00, 1'b1, 1'b0, 1'b1);
      checkOutput("mode00", 32'(o_data), 32'h112233);
      applyStimulus(1'b1, 24'h112233, 2'b01, 1'b1, 1'b0, 1'b1);
      checkOutput("mode01", 32'(o_data), 32'h332211);
      applyStimulus(1'b1, 24'h102030, 2'b10, 1'b1, 1'b0, 1'b1);
      checkOutput("mode10", 32'(o_data), 32'hEFDFCF);
      applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);
      checkOutput("mode_count", 32'(o_count), 32'h3);
      checkOutput("mode_drain", 32'(o_valid), 32'h0);

      // Backpressure: fill while downstream stalls, then release.
      pushed = 0;
      for (int cyc = 0; cyc < 40 && (pushed < 6 || o_valid); cyc++) begin
         acc = m_ready;
         applyStimulus(pushed < 6, DW'(pushed + 1), 2'b00, cyc >= 6, 1'b0, 1'b1);
         if (pushed < 6 && acc) pushed++;
         if (cyc == 5) begin
            checkOutput("full_ready", 32'(i_ready), 32'h0);
            checkOutput("full_hold", 32'(o_data), 32'h1);
         end
      end
      checkOutput("bp_pushed", 32'(pushed), 32'h6);
      checkOutput("bp_count", 32'(o_count), 32'h9);
      checkOutput("bp_drain", 32'(o_valid), 32'h0);

      // Concurrent push and pop for 100 consecutive pixels.
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, DW'(32'h100 + i), 2'b00, 1'b1, 1'b0, 1'b1);
         checkOutput("cc_ready", 32'(i_ready), 32'h1);
         checkOutput("cc_valid", 32'(o_valid), 32'h1);
      end
      applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);
      checkOutput("cc_count", 32'(o_count), 32'(109 % 16));

      // Reserved mode sets the sticky error and passes data through.
      applyStimulus(1'b1, 24'hABCDEF, 2'b11, 1'b1, 1'b0, 1'b1);
      checkOutput("rsvd_data", 32'(o_data), 32'hABCDEF);
      checkOutput("rsvd_err", 32'(o_error), 32'h1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);
         checkOutput("err_sticky", 32'(o_error), 32'h1);
      end
      applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1);
      checkOutput("err_clr", 32'(o_error), 32'h0);

      // Protocol violation: fill, stall one offer, then drop valid.
      pushed = 0;
      for (int i = 0; i < 5; i++) begin
         acc = m_ready;
         applyStimulus(1'b1, DW'(32'h200 + pushed), 2'b00, 1'b0, 1'b0, 1'b1);
         if (acc) pushed++;
      end
      checkOutput("viol_pre", 32'(o_error), 32'h0);
      applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
      checkOutput("viol_err", 32'(o_error), 32'h1);
      applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1);
      checkOutput("viol_clr", 32'(o_error), 32'h0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);

      // Clear in the same cycle as a reserved-mode push: set wins.
      applyStimulus(1'b1, 24'h123456, 2'b11, 1'b1, 1'b1, 1'b1);
      checkOutput("set_wins", 32'(o_error), 32'h1);
      applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1);
      checkOutput("clr_after", 32'(o_error), 32'h0);

      // Reset mid-operation with three pixels buffered.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(32'h300 + i), 2'b00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("mid_valid", 32'(o_valid), 32'h0);
      checkOutput("mid_count", 32'(o_count), 32'h0);
      checkOutput("mid_ready", 32'(i_ready), 32'h1);
      applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);
      checkOutput("mid_empty", 32'(o_valid), 32'h0);

      // Counter wrap: 17 deliveries on a 4-bit counter.
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, DW'(32'h400 + i), 2'b00, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);
      checkOutput("wrap_count", 32'(o_count), 32'h1);

      // Randomized traffic; upstream mostly holds a stalled pixel.
      pend = 1'b0;
      pend_d = '0;
      for (int i = 0; i < 600; i++) begin
         rr = ($urandom_range(0, 49) != 0);
         if (pend && $urandom_range(0, 19) != 0) begin
            rv = 1'b1;
            rd = pend_d;
         end else begin
            rv = ($urandom_range(0, 2) != 0);
            rd = DW'($urandom);
         end
         acc = m_ready;
         applyStimulus(rv, rd,
                       ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rr);
         pend   = rv && !acc && rr;
         pend_d = rd;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
